// File: rtl/pipe_skid_stage.sv
// Single pipeline stage with an optional two-entry skid buffer, flush and bubble
// insertion. With the skid buffer enabled, in_ready is registered so that no
// combinational path runs from out_ready back to upstream.
module pipe_skid_stage #(
  parameter int                DATA_W  = 65,
  parameter logic [DATA_W-1:0] BUBBLE  = DATA_W'(32'h0000_0013),
  parameter int                SKID_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic              ready_q;
  logic              ready_d;
  logic [1:0]        occ_q;
  logic [DATA_W-1:0] main_p0;
  logic [DATA_W-1:0] skid_p0;
  logic              xfer_in;
  logic              xfer_out;
  logic              load_main;
  logic              load_skid;
  logic              main_from_skid;

  function automatic logic [1:0] occ_of(input state_t s);
    case (s)
      ONE:     occ_of = 2'd1;
      FULL:    occ_of = 2'd2;
      default: occ_of = 2'd0;
    endcase
  endfunction

  assign xfer_in   = in_valid & in_ready;
  assign xfer_out  = out_valid & out_ready;
  assign out_valid = (state_q != EMPTY);
  assign out_data  = out_valid ? main_p0 : BUBBLE;
  assign occupancy = occ_q;
  // Without the skid entry the stage can only refill in the cycle it drains.
  assign in_ready  = (SKID_EN != 0) ? ready_q : (!out_valid | out_ready);

  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (xfer_in) begin
            state_d   = ONE;
            load_main = 1'b1;
          end
        end
        ONE: begin
          if (xfer_in && xfer_out) begin
            load_main = 1'b1;
          end else if (xfer_in) begin
            state_d   = FULL;
            load_skid = 1'b1;
          end else if (xfer_out) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (xfer_out) begin
            state_d        = ONE;
            load_main      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    ready_d = (state_d != FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      ready_q <= 1'b1;
      occ_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      occ_q   <= occ_of(state_d);
    end
  end

  // Payload stage: data only, never reset; out_data is masked to BUBBLE instead.
  always_ff @(posedge clk) begin
    if (load_main) main_p0 <= main_from_skid ? skid_p0 : in_data;
    if (load_skid) skid_p0 <= in_data;
  end

endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 Parameter DATA_W, default 65, payload width in bits (pc 32 + instr 32 + predictedTaken 1 for IF/ID use).
REQ-002 Parameter BUBBLE, default {33'h0, 32'h00000013} zero-extended to DATA_W, payload presented while out_valid is 0 (ADDI x0,x0,0 in the instruction field).
REQ-003 Parameter SKID_EN, default 1; 1 = two-entry skid buffer, 0 = single register with combinational in_ready.
REQ-004 clk  input  1  rising-edge clock, the only clock.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  upstream payload valid.
REQ-007 in_ready  output  1  stage can accept this cycle.
REQ-008 in_data  input  DATA_W  upstream payload.
REQ-009 out_valid  output  1  out_data holds a live entry.
REQ-010 out_ready  input  1  downstream consumes this cycle (0 = stall).
REQ-011 out_data  output  DATA_W  head payload, or BUBBLE when out_valid is 0.
REQ-012 flush  input  1  discard all held and incoming entries.
REQ-013 occupancy  output  2  live entries held (0..2).

Function
REQ-014 Transfer in = in_valid & in_ready; transfer out = out_valid & out_ready.
REQ-015 Latency from accepted input to out_valid is exactly 1 cycle; no combinational path from in_data to out_data.
REQ-016 Order is strictly preserved; no entry is duplicated or lost except by flush.
REQ-017 SKID_EN=1: in_ready is registered and equals (occupancy != 2); no combinational path from out_ready to in_ready.
REQ-018 SKID_EN=1 states: EMPTY (occ 0), ONE (main valid), FULL (main + skid valid).
REQ-019 EMPTY: transfer in -> ONE, main <= in_data; else stay.
REQ-020 ONE: in & out -> ONE, main <= in_data; in & !out -> FULL, skid <= in_data; !in & out -> EMPTY; neither -> hold.
REQ-021 FULL: out -> ONE, main <= skid; !out -> hold (in_ready 0, no accept).
REQ-022 SKID_EN=0: in_ready = !out_valid | out_ready; occupancy never exceeds 1; same 1-cycle latency.
REQ-023 Sustained in_valid=1 and out_ready=1 gives one transfer per cycle (full throughput) in both modes.
REQ-024 Flush has priority over every transfer: on the edge where flush=1, all entries invalidate, occupancy <= 0, the same-cycle input is dropped even if in_ready was 1.
REQ-025 Cycle after flush: out_valid 0, out_data = BUBBLE, in_ready 1.
REQ-026 A downstream transfer that is signalled in a flush cycle still counts as consumed, and the flush also removes any remaining entries.
REQ-027 Stall (out_ready 0) holds out_data and out_valid stable until transfer out or flush.
REQ-028 occupancy is registered and always equals the count of valid entries.

Reset
REQ-029 rst_n low asynchronously forces out_valid 0, out_data BUBBLE, occupancy 0, skid invalid, and in_ready 1 (SKID_EN=1).
REQ-030 Reset asserted mid-transfer drops all entries; the first edge after release behaves as EMPTY.
REQ-031 Payload registers may be left uninitialised, but out_data must be BUBBLE whenever out_valid is 0.

Verification
REQ-032 Stream: in 0xA,0xB,0xC back-to-back with out_ready=1 -> out 0xA,0xB,0xC on consecutive cycles, each 1 cycle later, occupancy 1.
REQ-033 Skid fill: occupancy 1 holding 0xA, out_ready=0, push 0xB -> occupancy 2, in_ready 0, out_data 0xA held; out_ready=1 -> 0xA, then 0xB, then EMPTY.
REQ-034 Flush over stall: FULL (0xA,0xB), in_valid=1 with 0xC, out_ready=0, flush=1 -> next cycle occupancy 0, out_valid 0, out_data 0x...00000013, 0xC never appears.
REQ-035 Async reset: assert rst_n=0 between edges while FULL -> outputs reach reset values immediately without a clock edge; after release, push 0xD -> out 0xD one cycle later.
REQ-036 SKID_EN=0 build: out_ready toggling 1,0,1 with continuous input -> in_ready mirrors !out_valid|out_ready each cycle, no loss, occupancy never 2.
REQ-037 Random valid/ready/flush with a scoreboard, 10k cycles, both SKID_EN values -> order preserved, no drops except flushed entries, throughput 1/cycle whenever both sides are ready.
